// File: rtl/as6d_app_video_status_fwft_reader.sv
// as6d_app_video_status_fwft_reader
//
// Read-side consumer of the video status FWFT async FIFO, in the read clock
// domain. It pops one DATA_WIDTH status word and sends it as BEAT_NUM beats of
// BEAT_WIDTH bits on a valid/ready stream, LSB beat first. It pops only when the
// FIFO head is valid, so underflow cannot happen. When the downstream is always
// ready, the next word is popped on the last beat of the current word, so there
// is no idle cycle between words.
//
// Optional feature: define AS6D_STATUS_RD_STALL_CNT_EN to build a saturating
// backpressure stall counter. Without it, stall_cnt is tied to zero.
//
// Ports:
//   clk, rst            read clock; asynchronous active-high reset
//   clear               synchronous clear; overrides all other activity
//   fifo_rd_data        FWFT head word
//   fifo_rd_data_val    head word valid (FIFO not empty)
//   fifo_rd_en          pop strobe to the FIFO (combinational)
//   out_data/out_valid  beat stream toward the status register / DMA path
//   out_ready           downstream ready
//   out_first/out_last  beat 0 / beat BEAT_NUM-1 markers
//   busy                a word is held (state SEND)
//   word_cnt            words popped, wrapping
//   stall_cnt           cycles with out_valid & ~out_ready, saturating
module as6d_app_video_status_fwft_reader #(
  parameter int DATA_WIDTH = 102,
  parameter int BEAT_WIDTH = 34,
  parameter int BEAT_NUM   = DATA_WIDTH / BEAT_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_data_val,
  output logic                  fifo_rd_en,
  output logic [BEAT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int IDX_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_NUM - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      beat_idx_reg, beat_idx_next;
  logic [DATA_WIDTH-1:0] word_reg, word_next;
  logic [CNT_WIDTH-1:0]  word_cnt_reg, word_cnt_next;

  logic sending;
  logic at_last;
  logic pop;
  logic xfer;

  // Beat slices of the held word, beat 0 in the least significant bits.
  logic [BEAT_WIDTH-1:0] beats [BEAT_NUM];

  for (genvar gi = 0; gi < BEAT_NUM; gi++) begin : g_beat
    assign beats[gi] = word_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
  end

  assign sending = (state_reg == SEND);
  assign at_last = sending && (beat_idx_reg == LAST_IDX);
  assign xfer    = sending & out_ready;

  // Pop from IDLE, or on the accepted last beat so the next word follows
  // with no bubble. rst is included so no pop is signalled during reset.
  assign pop = fifo_rd_data_val & ~clear & ~rst & (~sending | (at_last & out_ready));

  always_comb begin
    state_next    = state_reg;
    beat_idx_next = beat_idx_reg;
    word_next     = word_reg;
    word_cnt_next = word_cnt_reg;
    if (clear) begin
      // A partly sent word is dropped; the word register content is irrelevant
      // once in IDLE because the outputs are gated by the state.
      state_next    = IDLE;
      beat_idx_next = '0;
      word_cnt_next = '0;
    end else if (pop) begin
      state_next    = SEND;
      beat_idx_next = '0;
      word_next     = fifo_rd_data;
      word_cnt_next = word_cnt_reg + CNT_WIDTH'(1);
    end else if (xfer) begin
      if (at_last) begin
        state_next    = IDLE;
        beat_idx_next = '0;
      end else begin
        beat_idx_next = beat_idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_idx_reg <= '0;
      word_reg     <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_idx_reg <= beat_idx_next;
      word_reg     <= word_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

`ifdef AS6D_STATUS_RD_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (clear) begin
      stall_cnt_next = '0;
    end else if (sending && !out_ready && !(&stall_cnt_reg)) begin
      stall_cnt_next = stall_cnt_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

  assign fifo_rd_en = pop;
  assign out_valid  = sending;
  assign busy       = sending;
  assign out_first  = sending && (beat_idx_reg == '0);
  assign out_last   = at_last;
  assign out_data   = sending ? beats[beat_idx_reg] : '0;
  assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_as6d_app_video_status_fwft_reader.sv
// Bench for as6d_app_video_status_fwft_reader. A queue-based FIFO feeds the
// DUT; a beat scoreboard (every popped word expands into three expected beats)
// predicts the stream, the pop strobe and the counters. A second instance with
// a 4-bit counter exercises word_cnt wrap-around in a short run.
module tb_as6d_app_video_status_fwft_reader;

  localparam int DW = 102;
  localparam int BW = 34;
  localparam int BN = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_data_val;
  logic          out_ready;

  logic          fifo_rd_en, out_valid, out_first, out_last, busy;
  logic [BW-1:0] out_data;
  logic [CW-1:0] word_cnt, stall_cnt;

  logic          fifo_rd_en_s, out_valid_s, out_first_s, out_last_s, busy_s;
  logic [BW-1:0] out_data_s;
  logic [3:0]    word_cnt_s, stall_cnt_s;

  always #5 clk = ~clk;

  as6d_app_video_status_fwft_reader dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_data_val(fifo_rd_data_val),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .busy(busy), .word_cnt(word_cnt), .stall_cnt(stall_cnt)
  );

  as6d_app_video_status_fwft_reader #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .clear(clear),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_data_val(fifo_rd_data_val),
    .fifo_rd_en(fifo_rd_en_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_first(out_first_s), .out_last(out_last_s),
    .busy(busy_s), .word_cnt(word_cnt_s), .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    logic [BW-1:0] d;
    bit            f;
    bit            l;
  } beat_t;

  typedef struct {
    logic [DW-1:0] w;
    logic [BW-1:0] b0;
    logic [BW-1:0] b1;
    logic [BW-1:0] b2;
  } vec_t;

  logic [DW-1:0] fifo_q[$];
  beat_t         beat_q[$];
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_stall;
  logic [3:0]    m_stall_s;

  int n_checks = 0;
  int n_errors = 0;

  bit            obs_pop, obs_valid, obs_first, obs_last;
  logic [BW-1:0] obs_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the scoreboard,
  // advance the scoreboard, then move to the next falling edge.
  task automatic cycle(input bit clr, input bit rdy);
    bit            exp_valid, exp_pop;
    beat_t         hb;
    logic [DW-1:0] w;
    clear            = clr;
    out_ready        = rdy;
    fifo_rd_data_val = (fifo_q.size() != 0);
    fifo_rd_data     = fifo_rd_data_val ? fifo_q[0] : '0;
    #1;
    exp_valid = (beat_q.size() != 0);
    exp_pop   = fifo_rd_data_val && !clr &&
                (beat_q.size() == 0 || (beat_q.size() == 1 && rdy));
    obs_pop = fifo_rd_en; obs_valid = out_valid; obs_data = out_data;
    obs_first = out_first; obs_last = out_last;
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, exp_valid);
    chk("fifo_rd_en", fifo_rd_en, exp_pop);
    chk("word_cnt", word_cnt, m_cnt);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("small_ctrl", {out_valid_s, busy_s, fifo_rd_en_s}, {exp_valid, exp_valid, exp_pop});
    chk("small_word_cnt", word_cnt_s, m_cnt[3:0]);
    chk("small_stall_cnt", stall_cnt_s, m_stall_s);
    if (exp_valid) begin
      hb = beat_q[0];
      chk("out_data", out_data, hb.d);
      chk("out_first_last", {out_first, out_last}, {hb.f, hb.l});
      chk("small_beat", {out_data_s, out_first_s, out_last_s}, {hb.d, hb.f, hb.l});
    end else begin
      chk("idle_first_last", {out_first, out_last}, 2'b00);
    end
    if (clr) begin
      beat_q.delete();
      m_cnt = '0; m_stall = '0; m_stall_s = '0;
    end else begin
      if (exp_valid && rdy) void'(beat_q.pop_front());
`ifdef AS6D_STATUS_RD_STALL_CNT_EN
      if (exp_valid && !rdy) begin
        if (m_stall != '1) m_stall = m_stall + 1'b1;
        if (m_stall_s != '1) m_stall_s = m_stall_s + 1'b1;
      end
`endif
      if (exp_pop) begin
        w = fifo_q.pop_front();
        for (int i = 0; i < BN; i++)
          beat_q.push_back('{d: w[i*BW +: BW], f: (i == 0), l: (i == BN - 1)});
        m_cnt = m_cnt + 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((beat_q.size() != 0 || fifo_q.size() != 0) && n < 400) begin
      cycle(0, 1);
      n++;
    end
    chk("drain_timeout", n < 400, 1'b1);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  vec_t tbl[6];

  initial begin
    logic [BW-1:0] cap [BN];
    bit            capf [BN];
    bit            capl [BN];
    logic [BW-1:0] held;
    logic [CW-1:0] cnt0;
    logic [DW-1:0] wa, wb;
    int            nb;

    tbl[0] = '{w: 102'h2_AAAA_AAAA_5555_5555_0123_4567,
               b0: 34'h1_0123_4567, b1: 34'h2_9555_5555, b2: 34'h0_2AAA_AAAA};
    tbl[1] = '{w: '1, b0: 34'h3_FFFF_FFFF, b1: 34'h3_FFFF_FFFF, b2: 34'h3_FFFF_FFFF};
    tbl[2] = '{w: 102'd1, b0: 34'd1, b1: 34'd0, b2: 34'd0};
    tbl[3] = '{w: (102'd1 << 34), b0: 34'd0, b1: 34'd1, b2: 34'd0};
    tbl[4] = '{w: (102'd1 << 68), b0: 34'd0, b1: 34'd0, b2: 34'd1};
    tbl[5] = '{w: (102'd1 << 101), b0: 34'd0, b1: 34'd0, b2: 34'h2_0000_0000};

    m_cnt = '0; m_stall = '0; m_stall_s = '0;

    // Reset: all outputs quiet and no pop even with a valid head word.
    rst = 1'b1; clear = 1'b0; out_ready = 1'b1;
    fifo_rd_data_val = 1'b1; fifo_rd_data = tbl[0].w;
    #2;
    chk("rst_outputs", {out_valid, out_first, out_last, busy, fifo_rd_en},  5'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_word_cnt", word_cnt, '0);
    chk("rst_stall_cnt", stall_cnt, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cycle(0, 1);
    $display("reset: checks=%0d errors=%0d", n_checks, n_errors);

    // Table: single words with ready held high, beats compared to constants.
    for (int r = 0; r < 6; r++) begin
      drain();
      cnt0 = m_cnt;
      nb = 0;
      fifo_q.push_back(tbl[r].w);
      cycle(0, 1);
      chk("tbl_pop", obs_pop, 1'b1);
      for (int c = 0; c < 6; c++) begin
        cycle(0, 1);
        if (obs_valid && nb < BN) begin
          cap[nb] = obs_data; capf[nb] = obs_first; capl[nb] = obs_last;
          nb++;
        end
      end
      chk("tbl_nbeats", nb, BN);
      chk("tbl_beat0", {cap[0], capf[0], capl[0]}, {tbl[r].b0, 2'b10});
      chk("tbl_beat1", {cap[1], capf[1], capl[1]}, {tbl[r].b1, 2'b00});
      chk("tbl_beat2", {cap[2], capf[2], capl[2]}, {tbl[r].b2, 2'b01});
      chk("tbl_word_cnt", word_cnt, cnt0 + 1'b1);
      chk("tbl_busy_after", busy, 1'b0);
      $display("vector %0d: word=%h beats=%h %h %h", r, tbl[r].w, cap[0], cap[1], cap[2]);
    end

    // Back-to-back: four queued words, twelve contiguous beats.
    drain();
    cycle(1, 1);
    for (int i = 0; i < 4; i++) fifo_q.push_back(rand_word());
    for (int c = 0; c < 14; c++) begin
      cycle(0, 1);
      chk("b2b_rd_en", obs_pop, (c < 12) && (c % 3 == 0));
      chk("b2b_valid", obs_valid, (c >= 1) && (c <= 12));
    end
    chk("b2b_word_cnt", word_cnt, 16'd4);
    $display("back-to-back: word_cnt=%0d", word_cnt);

    // Backpressure: five stalled cycles on beat 1 with a second word waiting.
    cycle(1, 1);
    fifo_q.push_back(rand_word());
    fifo_q.push_back(rand_word());
    cycle(0, 1);
    cycle(0, 1);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0);
      chk("bp_held", obs_data, held);
      chk("bp_no_pop", obs_pop, 1'b0);
    end
`ifdef AS6D_STATUS_RD_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cnt, 16'd5);
`else
    chk("bp_stall_cnt", stall_cnt, 16'd0);
`endif
    $display("backpressure: held=%h stall_cnt=%0d", held, stall_cnt);
    drain();

    // Empty FIFO for 20 cycles.
    cnt0 = m_cnt;
    for (int c = 0; c < 20; c++) begin
      cycle(0, 1);
      chk("empty_idle", {obs_pop, obs_valid}, 2'b00);
    end
    chk("empty_word_cnt", word_cnt, cnt0);
    $display("empty: word_cnt=%0d", word_cnt);

    // Clear during beat 1 while another word waits.
    wa = rand_word(); wb = rand_word();
    fifo_q.push_back(wa); fifo_q.push_back(wb);
    cycle(0, 1);
    cycle(0, 1);
    cycle(1, 1);
    chk("clr_no_pop", obs_pop, 1'b0);
    cycle(0, 1);
    chk("clr_valid_low", obs_valid, 1'b0);
    chk("clr_pop_next", obs_pop, 1'b1);
    cycle(0, 1);
    chk("clr_first_beat", {obs_valid, obs_first, obs_data}, {2'b11, wb[BW-1:0]});
    chk("clr_word_cnt", word_cnt, 16'd1);
    $display("clear mid-word: resumed beat0=%h word_cnt=%0d", obs_data, word_cnt);
    drain();

    // Wrap on the 4-bit instance: 17 pops bring it back to 1.
    cycle(1, 1);
    for (int i = 0; i < 17; i++) fifo_q.push_back(rand_word());
    drain();
    chk("wrap_small_cnt", word_cnt_s, 4'd1);
    chk("wrap_wide_cnt", word_cnt, 16'd17);
    $display("wrap: small word_cnt=%0d wide word_cnt=%0d", word_cnt_s, word_cnt);

    // Randomised traffic, backpressure and occasional clears.
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) fifo_q.push_back(rand_word());
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
    end
    drain();
    $display("random: word_cnt=%0d stall_cnt=%0d", word_cnt, stall_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
